// File: rtl/stopwatch_ctrl.sv
// Control FSM for a four-digit BCD stopwatch built from cascaded decade counters.
// It divides clk into count ticks, sequences start/stop/clear/lap commands and shows either the live count or a frozen lap value.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 10,
   parameter int PRE_W    = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        lap,
   output logic [15:0] digits,
   output logic        running,
   output logic        tick,
   output logic        lap_valid,
   output logic        ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   state_t            state, state_next;
   logic [PRE_W-1:0]  prescaler, prescaler_next;
   logic [3:0][3:0]   count, count_next;
   logic [15:0]       lap_reg, lap_reg_next;
   logic              lap_valid_next;
   logic              ovf_next;
   logic [3:0]        inc;
   logic              wrap;
   logic              cmd_clear, cmd_stop, cmd_start, cmd_lap;

   // A single command acts per cycle; the highest-priority pulse masks the rest.
   assign cmd_clear = clear;
   assign cmd_stop  = stop  & ~clear;
   assign cmd_start = start & ~clear & ~stop;
   assign cmd_lap   = lap   & ~clear & ~stop & ~start;

   assign tick = (state == RUN) && (prescaler == PRE_LAST);

   assign inc[0] = tick;
   assign inc[1] = inc[0] && (count[0] == 4'd9);
   assign inc[2] = inc[1] && (count[1] == 4'd9);
   assign inc[3] = inc[2] && (count[2] == 4'd9);
   assign wrap   = inc[3] && (count[3] == 4'd9);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         prescaler <= '0;
         count     <= '0;
         lap_reg   <= '0;
         lap_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         state     <= state_next;
         prescaler <= prescaler_next;
         count     <= count_next;
         lap_reg   <= lap_reg_next;
         lap_valid <= lap_valid_next;
         ovf       <= ovf_next;
      end
   end

   always_comb begin
      state_next     = state;
      prescaler_next = prescaler;
      count_next     = count;
      lap_reg_next   = lap_reg;
      lap_valid_next = lap_valid;
      ovf_next       = ovf;

      for (int k = 0; k < 4; k++) begin
         if (inc[k]) begin
            count_next[k] = (count[k] == 4'd9) ? 4'd0 : count[k] + 4'd1;
         end
      end
      if (wrap) begin
         ovf_next = 1'b1;
      end

      // Prescaler holds in PAUSE so a resumed partial period completes.
      case (state)
         RUN:     prescaler_next = tick ? '0 : prescaler + PRE_W'(1);
         PAUSE:   prescaler_next = prescaler;
         default: prescaler_next = '0;
      endcase

      case (state)
         IDLE:    if (cmd_start) state_next = RUN;
         RUN:     if (cmd_stop)  state_next = PAUSE;
         PAUSE:   if (cmd_start) state_next = RUN;
         default: state_next = IDLE;
      endcase

      // Lap captures the count as it will be after this edge's increment.
      if (cmd_lap && (state != IDLE)) begin
         if (!lap_valid) begin
            lap_reg_next   = count_next;
            lap_valid_next = 1'b1;
         end else begin
            lap_valid_next = 1'b0;
         end
      end

      if (cmd_clear) begin
         state_next     = IDLE;
         prescaler_next = '0;
         count_next     = '0;
         lap_reg_next   = '0;
         lap_valid_next = 1'b0;
         ovf_next       = 1'b0;
      end
   end

   assign digits  = lap_valid ? lap_reg : count;
   assign running = (state == RUN);

endmodule
